// File: rtl/accumulator_pkg.sv
// Shared constants for the 16-bit accumulator datapath: widths, reset PC,
// halt opcode, fetch FSM encodings and next-PC select codes.
package accumulator_pkg;

  localparam int unsigned     PC_W        = 10;
  localparam int unsigned     INSTR_W     = 16;
  localparam logic [PC_W-1:0] RESET_PC    = 10'h000;
  localparam logic [3:0]      HALT_OPCODE = 4'hF;

  // Fetch FSM encodings, kept as plain constants for legacy compatibility
  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  // Next-fetch_pc selection
  localparam logic [1:0] SEL_HOLD   = 2'd0;
  localparam logic [1:0] SEL_INC    = 2'd1;
  localparam logic [1:0] SEL_BRANCH = 2'd2;

endpackage

// File: rtl/fetch_unit_pc_next_sel.sv
// Combinational next-fetch_pc mux: hold, increment (modulo 2**PC_W) or
// branch target.
module pc_next_sel #(
  parameter int unsigned PC_W = 10
) (
  input  logic [1:0]      sel,
  input  logic [PC_W-1:0] fetchPc,
  input  logic [PC_W-1:0] branchTarget,
  output logic [PC_W-1:0] nextPc
);
  import accumulator_pkg::SEL_HOLD;
  import accumulator_pkg::SEL_INC;
  import accumulator_pkg::SEL_BRANCH;

  always_comb begin
    nextPc = fetchPc;
    case (sel)
      SEL_HOLD:   nextPc = fetchPc;
      SEL_INC:    nextPc = fetchPc + PC_W'(1);
      SEL_BRANCH: nextPc = branchTarget;
      default:    nextPc = fetchPc;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns fetch_pc, drives instruction memory and
// latches {PC, instr}. Define FETCH_HALT_EN to enable the S_HALT state.
module fetch_unit #(
  parameter int unsigned     PC_W     = accumulator_pkg::PC_W,
  parameter int unsigned     INSTR_W  = accumulator_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = accumulator_pkg::RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_rd_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]    PC,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid
);
  import accumulator_pkg::*;

  logic [1:0]      state;
  logic [1:0]      stateNext;
  logic [1:0]      pcSel;
  logic [PC_W-1:0] fetchPc;
  logic [PC_W-1:0] nextPc;
  logic [PC_W-1:0] issuedPc;
  logic            rdEn;
  logic            loadInstr;
  logic            clearValid;

  always_comb begin
    stateNext  = state;
    pcSel      = SEL_HOLD;
    rdEn       = 1'b0;
    loadInstr  = 1'b0;
    clearValid = 1'b0;
    case (state)
      S_BOOT: begin
        rdEn      = 1'b1;
        pcSel     = SEL_INC;
        stateNext = S_RUN;
      end
      S_RUN: begin
        rdEn = ~stall | branch_taken;
        if (branch_taken) begin
          pcSel      = SEL_BRANCH;
          clearValid = 1'b1;
          stateNext  = S_FLUSH;
        end else if (!stall) begin
          pcSel     = SEL_INC;
          loadInstr = 1'b1;
`ifdef FETCH_HALT_EN
          if (imem_rdata[INSTR_W-1 -: 4] == HALT_OPCODE) begin
            stateNext = S_HALT;
          end
`endif
        end
      end
      S_FLUSH: begin
        // Word returning now was fetched from the wrong path
        rdEn       = 1'b1;
        pcSel      = SEL_INC;
        clearValid = 1'b1;
        stateNext  = S_RUN;
      end
`ifdef FETCH_HALT_EN
      S_HALT: begin
        stateNext = S_HALT;
      end
`endif
      default: begin
        stateNext = S_BOOT;
      end
    endcase
  end

  pc_next_sel #(
    .PC_W(PC_W)
  ) uPcNextSel (
    .sel         (pcSel),
    .fetchPc     (fetchPc),
    .branchTarget(branch_target),
    .nextPc      (nextPc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_BOOT;
      fetchPc     <= RESET_PC;
      issuedPc    <= RESET_PC;
      PC          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      state   <= stateNext;
      fetchPc <= nextPc;
      // Address the memory captured this edge; its data is latched next edge
      if (rdEn) begin
        issuedPc <= fetchPc;
      end
      if (loadInstr) begin
        instr       <= imem_rdata;
        PC          <= issuedPc;
        instr_valid <= 1'b1;
      end else if (clearValid) begin
        instr_valid <= 1'b0;
      end
    end
  end

  assign imem_addr  = fetchPc;
  assign imem_rd_en = rdEn;

endmodule
